// File: rtl/pipe_ctrl.sv
// Pipeline hazard/redirect/halt controller: register scoreboard, stall and flush
// generation, halt drain sequencing and a saturating stall counter.
module pipe_ctrl #(
    parameter int REG_ADDR_LEN = 5,
    parameter int PC_W         = 30,
    parameter int FLUSH_CYC    = 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    id_valid,
    input  logic                    id_rs1_en,
    input  logic                    id_rs2_en,
    input  logic                    id_rd_en,
    input  logic [REG_ADDR_LEN-1:0] id_rs1,
    input  logic [REG_ADDR_LEN-1:0] id_rs2,
    input  logic [REG_ADDR_LEN-1:0] id_rd,
    input  logic                    id_is_halt,
    input  logic                    wb_en,
    input  logic [REG_ADDR_LEN-1:0] wb_rd,
    input  logic                    br_taken,
    input  logic [PC_W-1:0]         br_target,
    output logic                    stall_if,
    output logic                    stall_id,
    output logic                    bubble_ex,
    output logic                    flush_ifid,
    output logic                    pc_load,
    output logic [PC_W-1:0]         pc_load_val,
    output logic                    halt,
    output logic [15:0]             perf_stall_cnt
);

    localparam int NREG = 1 << REG_ADDR_LEN;
    localparam logic [2:0] FLUSH_INIT = 3'(FLUSH_CYC - 1);

    typedef enum logic [1:0] {S_RUN, S_FLUSH, S_DRAIN, S_HALTED} state_t;

    state_t          state;
    logic [NREG-1:0] busy;
    logic [NREG-1:0] busy_nxt;
    logic [2:0]      flush_cnt;
    logic            rs1_pend;
    logic            rs2_pend;
    logic            hazard;
    logic            issue;

    // A write retiring this cycle satisfies the read, so it never stalls.
    assign rs1_pend = id_rs1_en && (id_rs1 != '0) && busy[id_rs1] &&
                      !(wb_en && (wb_rd == id_rs1));
    assign rs2_pend = id_rs2_en && (id_rs2 != '0) && busy[id_rs2] &&
                      !(wb_en && (wb_rd == id_rs2));
    assign hazard   = id_valid && (rs1_pend || rs2_pend);
    assign issue    = (state == S_RUN) && id_valid && !br_taken && !hazard;

    always_comb begin
        busy_nxt = busy;
        if (wb_en)
            busy_nxt[wb_rd] = 1'b0;
        if (issue && id_rd_en && (id_rd != '0))
            busy_nxt[id_rd] = 1'b1;
        busy_nxt[0] = 1'b0;
    end

    always_comb begin
        stall_if    = 1'b0;
        stall_id    = 1'b0;
        bubble_ex   = 1'b0;
        flush_ifid  = 1'b0;
        pc_load     = 1'b0;
        pc_load_val = '0;
        halt        = 1'b0;
        case (state)
            S_RUN: begin
                if (br_taken) begin
                    pc_load     = 1'b1;
                    pc_load_val = br_target;
                    flush_ifid  = 1'b1;
                    bubble_ex   = 1'b1;
                end else if (hazard) begin
                    stall_if  = 1'b1;
                    stall_id  = 1'b1;
                    bubble_ex = 1'b1;
                end
            end
            S_FLUSH: bubble_ex = 1'b1;
            S_DRAIN: begin
                stall_if  = 1'b1;
                stall_id  = 1'b1;
                bubble_ex = 1'b1;
            end
            default: begin
                halt      = 1'b1;
                stall_if  = 1'b1;
                stall_id  = 1'b1;
                bubble_ex = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= S_RUN;
            busy           <= '0;
            flush_cnt      <= '0;
            perf_stall_cnt <= '0;
        end else begin
            busy <= busy_nxt;
            case (state)
                S_RUN: begin
                    if (br_taken) begin
                        flush_cnt <= FLUSH_INIT;
                        if (FLUSH_CYC > 1)
                            state <= S_FLUSH;
                    end else if (hazard) begin
                        if (perf_stall_cnt != 16'hFFFF)
                            perf_stall_cnt <= perf_stall_cnt + 16'd1;
                    end else if (issue && id_is_halt) begin
                        state <= S_DRAIN;
                    end
                end
                S_FLUSH: begin
                    // Leave once the count reaches zero; the redirect cycle was the first bubble.
                    flush_cnt <= flush_cnt - 3'd1;
                    if (flush_cnt <= 3'd1)
                        state <= S_RUN;
                end
                S_DRAIN: begin
                    if (busy_nxt == '0)
                        state <= S_HALTED;
                end
                default: state <= S_HALTED;
            endcase
        end
    end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Scoreboard bench for pipe_ctrl: directed scenarios plus random traffic checked
// against a queue of expectations from a behavioural model.
module tb_pipe_ctrl;

    localparam int RA = 5;
    localparam int PW = 30;
    localparam int FC = 3;

    localparam int M_RUN = 0, M_FLUSH = 1, M_DRAIN = 2, M_HALTED = 3;

    typedef struct packed {
        logic          stall_if;
        logic          stall_id;
        logic          bubble_ex;
        logic          flush_ifid;
        logic          pc_load;
        logic [PW-1:0] pcv;
        logic          halt;
        logic [15:0]   perf;
    } out_t;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          id_valid, id_rs1_en, id_rs2_en, id_rd_en, id_is_halt;
    logic [RA-1:0] id_rs1, id_rs2, id_rd, wb_rd;
    logic          wb_en, br_taken;
    logic [PW-1:0] br_target;
    logic          stall_if, stall_id, bubble_ex, flush_ifid, pc_load, halt;
    logic [PW-1:0] pc_load_val;
    logic [15:0]   perf_stall_cnt;

    int errors = 0;
    int checks = 0;

    out_t  exp_q[$];
    string nm_q[$];

    // Behavioural model state
    int m_mode;
    int m_left;
    int m_perf;
    bit m_busy[1 << RA];

    always #5 clk = ~clk;

    pipe_ctrl #(.REG_ADDR_LEN(RA), .PC_W(PW), .FLUSH_CYC(FC)) dut (
        .clk(clk), .rst_n(rst_n),
        .id_valid(id_valid), .id_rs1_en(id_rs1_en), .id_rs2_en(id_rs2_en),
        .id_rd_en(id_rd_en), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
        .id_is_halt(id_is_halt), .wb_en(wb_en), .wb_rd(wb_rd),
        .br_taken(br_taken), .br_target(br_target),
        .stall_if(stall_if), .stall_id(stall_id), .bubble_ex(bubble_ex),
        .flush_ifid(flush_ifid), .pc_load(pc_load), .pc_load_val(pc_load_val),
        .halt(halt), .perf_stall_cnt(perf_stall_cnt)
    );

    function automatic bit pending(input logic [RA-1:0] r);
        return (r != 0) && m_busy[r] && !(wb_en && wb_rd == r);
    endfunction

    task automatic idle();
        rst_n = 1'b1; id_valid = 0; id_rs1_en = 0; id_rs2_en = 0; id_rd_en = 0;
        id_is_halt = 0; id_rs1 = 0; id_rs2 = 0; id_rd = 0;
        wb_en = 0; wb_rd = 0; br_taken = 0; br_target = 0;
    endtask

    // Called at posedge+1 with inputs set; predicts this cycle's outputs, advances the model.
    task automatic step(input string nm);
        out_t e;
        int   cur;
        bit   hz, issued, anyb;
        if (!rst_n) begin
            m_mode = M_RUN; m_left = 0; m_perf = 0;
            foreach (m_busy[i]) m_busy[i] = 0;
        end
        e = '0;
        e.perf = 16'(m_perf);
        hz = id_valid && ((id_rs1_en && pending(id_rs1)) || (id_rs2_en && pending(id_rs2)));
        issued = 0;
        cur = m_mode;
        case (cur)
            M_RUN: begin
                if (br_taken) begin
                    e.pc_load = 1; e.pcv = br_target; e.flush_ifid = 1; e.bubble_ex = 1;
                    if (rst_n && FC > 1) begin m_mode = M_FLUSH; m_left = FC - 1; end
                end else if (hz) begin
                    e.stall_if = 1; e.stall_id = 1; e.bubble_ex = 1;
                    if (rst_n && m_perf < 65535) m_perf++;
                end else if (id_valid) begin
                    issued = 1;
                    if (rst_n && id_is_halt) m_mode = M_DRAIN;
                end
            end
            M_FLUSH: begin
                e.bubble_ex = 1;
                m_left--;
                if (m_left == 0) m_mode = M_RUN;
            end
            M_DRAIN: begin
                e.stall_if = 1; e.stall_id = 1; e.bubble_ex = 1;
            end
            default: begin
                e.halt = 1; e.stall_if = 1; e.stall_id = 1; e.bubble_ex = 1;
            end
        endcase
        if (rst_n) begin
            if (wb_en) m_busy[wb_rd] = 0;
            if (issued && id_rd_en && id_rd != 0) m_busy[id_rd] = 1;
            if (cur == M_DRAIN) begin
                anyb = 0;
                foreach (m_busy[i]) anyb |= m_busy[i];
                if (!anyb) m_mode = M_HALTED;
            end
        end
        exp_q.push_back(e);
        nm_q.push_back(nm);
        @(posedge clk);
        #1;
    endtask

    task automatic issue_rd(input logic [RA-1:0] r, input string nm);
        idle(); id_valid = 1; id_rd_en = 1; id_rd = r;
        step(nm);
    endtask

    task automatic do_reset();
        idle(); rst_n = 0;
        step("reset");
        idle();
    endtask

    // Monitor: compares DUT outputs mid-cycle against the oldest expectation.
    always @(negedge clk) begin
        out_t  a, e;
        string n;
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            n = nm_q.pop_front();
            a = {stall_if, stall_id, bubble_ex, flush_ifid, pc_load, pc_load_val, halt, perf_stall_cnt};
            checks++;
            if (a !== e) begin
                errors++;
                $display("FAIL %s: got sif=%b sid=%b bex=%b fl=%b pcl=%b pcv=%h halt=%b perf=%h, expected sif=%b sid=%b bex=%b fl=%b pcl=%b pcv=%h halt=%b perf=%h",
                         n, a.stall_if, a.stall_id, a.bubble_ex, a.flush_ifid, a.pc_load, a.pcv, a.halt, a.perf,
                         e.stall_if, e.stall_id, e.bubble_ex, e.flush_ifid, e.pc_load, e.pcv, e.halt, e.perf);
            end
        end
    end

    initial begin
        idle();
        rst_n = 0;
        @(posedge clk);
        #1;
        do_reset();
        step("reset_release");

        // RAW hazard until the producer retires
        issue_rd(3, "raw_issue");
        idle(); id_valid = 1; id_rs1_en = 1; id_rs1 = 3;
        repeat (3) step("raw_stall");
        wb_en = 1; wb_rd = 3;
        step("raw_wb_release");

        // Redirect with a hazard present: flush wins, stall counter frozen
        do_reset();
        issue_rd(3, "br_issue");
        idle(); id_valid = 1; id_rs1_en = 1; id_rs1 = 3;
        br_taken = 1; br_target = 30'h100;
        step("br_redirect");
        br_taken = 0;
        step("br_flush1");
        step("br_flush2");
        step("br_after");

        // Halt drain waits for r5, ignores redirects
        do_reset();
        issue_rd(5, "drain_issue5");
        idle(); id_valid = 1; id_is_halt = 1;
        step("halt_issue");
        idle();
        step("drain_wait");
        br_taken = 1; br_target = 30'h2AA;
        step("drain_br_ignored");
        idle(); wb_en = 1; wb_rd = 5;
        step("drain_wb5");
        idle();
        repeat (3) step("halted_sticky");

        // Same-cycle retire and reissue of r7, and r0 never busy
        do_reset();
        issue_rd(7, "r7_first");
        idle(); id_valid = 1; id_rd_en = 1; id_rd = 7; wb_en = 1; wb_rd = 7;
        step("r7_set_wins");
        idle(); id_valid = 1; id_rs1_en = 1; id_rs1 = 7;
        step("r7_still_busy");
        issue_rd(0, "r0_issue");
        idle(); id_valid = 1; id_rs1_en = 1; id_rs1 = 0; id_rs2_en = 1; id_rs2 = 0;
        step("r0_no_stall");

        // Stall counter saturation
        do_reset();
        issue_rd(3, "sat_issue");
        idle(); id_valid = 1; id_rs1_en = 1; id_rs1 = 3;
        repeat (65537) step("sat_hazard");

        // Asynchronous reset in the middle of a drain
        do_reset();
        issue_rd(5, "adr_issue5");
        idle(); id_valid = 1; id_rs1_en = 1; id_rs1 = 5;
        step("adr_hazard");
        idle(); id_valid = 1; id_is_halt = 1;
        step("adr_halt");
        idle();
        step("adr_drain");
        #2;
        rst_n = 0;
        #1;
        checks++;
        if ({halt, stall_if, stall_id, bubble_ex, perf_stall_cnt} !== 20'h0) begin
            errors++;
            $display("FAIL async_reset: got halt=%b sif=%b sid=%b bex=%b perf=%h, expected all zero",
                     halt, stall_if, stall_id, bubble_ex, perf_stall_cnt);
        end
        @(posedge clk);
        #1;
        step("adr_held");
        idle();
        step("adr_release");
        idle(); id_valid = 1; id_rs1_en = 1; id_rs1 = 5;
        step("adr_no_residual");

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            if (m_mode == M_HALTED && $urandom_range(0, 3) == 0)
                rst_n = 0;
            else
                rst_n = ($urandom_range(0, 299) != 0);
            id_valid   = ($urandom_range(0, 3) != 0);
            id_rs1_en  = 1'($urandom);
            id_rs2_en  = 1'($urandom);
            id_rd_en   = 1'($urandom);
            id_rs1     = RA'($urandom_range(0, 7));
            id_rs2     = RA'($urandom_range(0, 7));
            id_rd      = RA'($urandom_range(0, 7));
            id_is_halt = ($urandom_range(0, 59) == 0);
            wb_en      = ($urandom_range(0, 2) == 0);
            wb_rd      = RA'($urandom_range(0, 7));
            br_taken   = ($urandom_range(0, 9) == 0);
            br_target  = PW'($urandom);
            step("random");
        end

        idle();
        @(negedge clk);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain_queue: got %0d pending expectations, expected 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
